logicnet_input_quantizer: RTL and testbench
===========================================

# logicnet_input_quantizer

Streaming input stage for the LogicNet classifier: accepts one signed raw feature per beat and quantizes it to a 2-bit code against per-feature thresholds. It assembles a full feature vector and presents it to the layer-0 neuron LUTs as one packed word with valid/ready flow control. A double buffer (assembly register plus output register) lets the next sample load while the current vector is held for layer 0.

## Interface

- `NUM_FEATURES`, 49: features per sample vector.
- `IN_W`, 16: raw feature width, two's-complement.
- `Q_BITS`, 2: code width per feature. Fixed by the package; not overridable.

- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: stage can accept a beat.
- `s_data`, in, `IN_W`: raw feature value.
- `s_last`, in, 1: marks the final feature of a sample.
- `m_valid`, out, 1: packed vector valid.
- `m_ready`, in, 1: layer 0 / pipeline register accepts the vector.
- `m_data`, out, `NUM_FEATURES*Q_BITS`: feature i occupies bits [i*2+1:i*2].
- `err_frame`, out, 1: one-cycle pulse on an `s_last` / index mismatch.

## Operation

- A beat is accepted when `s_valid && s_ready`.
- Quantization is combinational.
  - code = (d ≥ t0) + (d ≥ t1) + (d ≥ t2), using signed compares.
  - Thresholds t0 ≤ t1 ≤ t2 are selected by the current feature index.
  - The code is written into assembly slot `idx` on acceptance.
- Feature index counter `idx` runs from 0 to NUM_FEATURES-1. It wraps to 0 after the final feature, after an early `s_last`, or on reset.
- Frame close: the beat with `idx == NUM_FEATURES-1` always closes the frame.
  - If the output register is empty, or is being drained in the same cycle (`m_valid && m_ready`), the completed vector, including the final code, loads straight into the output register.
  - Otherwise `a_full` is set and `s_ready` drops until the output register frees.
- Early `s_last` (idx < NUM_FEATURES-1):
  - The partial frame is discarded and idx returns to 0.
  - `err_frame` pulses; no vector is emitted.
- Missing `s_last` on the closing beat: the frame is still delivered and `err_frame` pulses.
- `s_ready = !a_full`.
- `m_valid` stays asserted and `m_data` stays stable until `m_ready`.
- Reset mid-frame: the partial frame and any held vector are lost. No error is flagged.

## Timing

- Reset values:
  - `s_ready` = 1 (on the first cycle after release)
  - `m_valid` = 0, `m_data` = 0, `err_frame` = 0
  - idx = 0, `a_full` = 0
- Latency: closing beat accepted at edge E gives `m_valid` high in the cycle after E, when the output register is free.
- When `a_full` is set, the A→O transfer happens at the edge where `m_ready && m_valid` holds. `s_ready` rises in the next cycle.
- Throughput: one feature per cycle sustained when `m_ready` is held high. There is no bubble between frames.
- `err_frame` is registered and asserts in the cycle after the offending beat.

## Configuration

- `LOGICNET_IN_STATS_EN` defined:
  - Adds 32-bit outputs `frame_cnt` (vectors delivered on O) and `err_cnt` (`err_frame` pulses).
  - Both reset to 0 and wrap silently.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure

- Package `logicnet_in_pkg` holds:
  - `Q_BITS` = 2 and `NUM_THRESH` = 3
  - typedef `qcode_t` (logic [1:0])
  - typedef `thresh_set_t` (three signed `IN_W` values)
- Sub-module `logicnet_in_thresh_rom`:
  - Combinational; indexed by idx and returns `thresh_set_t`.
  - Contents come from a generated include file produced by the same flow that emits the neuron LUTs.

## Test plan

Bench configuration: NUM_FEATURES=3, thresholds {-100, 0, 100} for every feature.

- Single frame: beats -200, 50, 300 with `s_last` on the third, `m_ready`=1 → `m_data`=6'b11_10_00 one cycle after the third beat; `err_frame`=0.
- Boundary values: beats -100, 0, 100 → codes 1, 2, 3, giving `m_data`=6'b11_10_01.
- Backpressure: `m_ready`=0; two full frames sent → second frame sets `a_full` and `s_ready`=0; a third frame's first beat stalls. `m_ready` pulsed → first vector consumed, second appears the next cycle, `s_ready` returns to 1.
- Early `s_last` on the second beat → `err_frame` pulses once, no `m_valid`. The next 3-beat frame is delivered correctly.
- Missing `s_last` on the third beat → vector delivered and `err_frame` pulses.
- `rst_n` asserted after one beat of a frame → all outputs return to reset values. A fresh 3-beat frame delivers normally; with `LOGICNET_IN_STATS_EN`, `frame_cnt`=1.

Source files
------------

// File: rtl/logicnet_in_pkg.sv
// Shared types and constants for the LogicNet input quantizer.
package logicnet_in_pkg;

  localparam int Q_BITS     = 2;
  localparam int NUM_THRESH = 3;
  localparam int THR_W      = 16;

  typedef logic [Q_BITS-1:0] qcode_t;

  typedef struct packed {
    logic signed [THR_W-1:0] t2;
    logic signed [THR_W-1:0] t1;
    logic signed [THR_W-1:0] t0;
  } thresh_set_t;

endpackage

// File: rtl/logicnet_in_thresh_rom.sv
// Per-feature threshold table. The case body below is the part the LUT generation
// flow rewrites; the stock table uses {-100, 0, 100} for every feature.
module logicnet_in_thresh_rom
  import logicnet_in_pkg::*;
#(
  parameter int NUM_FEATURES = 49,
  parameter int IDX_W        = 6
) (
  input  logic [IDX_W-1:0] idx,
  output thresh_set_t      thr
);

  always_comb begin
    thr.t0 = THR_W'(-100);
    thr.t1 = THR_W'(0);
    thr.t2 = THR_W'(100);
    // Indices past the last feature never occur; give them a neutral all-zero set.
    if (int'(idx) >= NUM_FEATURES) begin
      thr = '0;
    end
  end

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Streaming 2-bit input quantizer with assembly/output double buffer for LogicNet layer 0.
// Optional LOGICNET_IN_STATS_EN adds frame_cnt / err_cnt statistics outputs.
module logicnet_input_quantizer #(
  parameter int NUM_FEATURES = 49,
  parameter int IN_W         = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [IN_W-1:0]                              s_data,
  input  logic                                         s_last,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [NUM_FEATURES*logicnet_in_pkg::Q_BITS-1:0] m_data,
  output logic                                         err_frame
`ifdef LOGICNET_IN_STATS_EN
  ,
  output logic [31:0]                                  frame_cnt,
  output logic [31:0]                                  err_cnt
`endif
);
  import logicnet_in_pkg::*;

  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int VEC_W = NUM_FEATURES * Q_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  logic [IDX_W-1:0] idx;
  logic             a_full;
  logic [VEC_W-1:0] asm_data_p0;
  logic [VEC_W-1:0] asm_next;
  logic [VEC_W-1:0] out_data_p1;
  logic             vld_p1;
  thresh_set_t      thr;
  qcode_t           code_p0;
  logic             acc, at_last, close, o_free, drain;

  function automatic qcode_t quantize(input logic signed [IN_W-1:0] d, input thresh_set_t t);
    qcode_t c;
    c = {1'b0, (d >= $signed(t.t0))} + {1'b0, (d >= $signed(t.t1))} + {1'b0, (d >= $signed(t.t2))};
    return c;
  endfunction

  logicnet_in_thresh_rom #(
    .NUM_FEATURES(NUM_FEATURES),
    .IDX_W       (IDX_W)
  ) u_rom (
    .idx(idx),
    .thr(thr)
  );

  // Stage p0: combinational quantize and merge into the assembly vector
  always_comb begin
    code_p0  = quantize($signed(s_data), thr);
    asm_next = asm_data_p0;
    asm_next[idx*Q_BITS +: Q_BITS] = code_p0;
  end

  assign s_ready = !a_full;
  assign acc     = s_valid && s_ready;
  assign at_last = (idx == LAST_IDX);
  assign close   = acc && at_last;
  assign drain   = vld_p1 && m_ready;
  assign o_free  = !vld_p1 || m_ready;

  always_ff @(posedge clk) begin
    if (acc) begin
      asm_data_p0 <= asm_next;
    end
  end

  // Stage p1: output register and frame control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      a_full      <= 1'b0;
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
      err_frame   <= 1'b0;
    end else begin
      err_frame <= acc && (s_last != at_last);
      if (acc) begin
        idx <= (at_last || s_last) ? '0 : idx + 1'b1;
      end
      if (a_full && m_ready) begin
        out_data_p1 <= asm_data_p0;
        a_full      <= 1'b0;
      end else if (close && o_free) begin
        out_data_p1 <= asm_next;
        vld_p1      <= 1'b1;
      end else begin
        if (close) a_full <= 1'b1;
        if (drain) vld_p1 <= 1'b0;
      end
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = out_data_p1;

`ifdef LOGICNET_IN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (drain)     frame_cnt <= frame_cnt + 32'd1;
      if (err_frame) err_cnt   <= err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Directed bench for logicnet_input_quantizer with 3 features and thresholds {-100, 0, 100}.
module tb_logicnet_input_quantizer;

  localparam int NF = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [15:0]       s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [NF*2-1:0]   m_data;
  logic              err_frame;
`ifdef LOGICNET_IN_STATS_EN
  logic [31:0]       frame_cnt;
  logic [31:0]       err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logicnet_input_quantizer #(
    .NUM_FEATURES(NF),
    .IN_W        (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .err_frame(err_frame)
`ifdef LOGICNET_IN_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] d0, d1, d2;
    logic [2:0]         last;
    logic [5:0]         exp_data;
    logic               exp_err;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic signed [15:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles", n);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{d0: -16'sd200, d1: 16'sd50,     d2: 16'sd300, last: 3'b100, exp_data: 6'b11_10_00, exp_err: 1'b0};
    tbl[1] = '{d0: -16'sd100, d1: 16'sd0,      d2: 16'sd100, last: 3'b100, exp_data: 6'b11_10_01, exp_err: 1'b0};
    tbl[2] = '{d0: 16'sd32767, d1: -16'sd32768, d2: 16'sd99, last: 3'b100, exp_data: 6'b10_00_11, exp_err: 1'b0};
    tbl[3] = '{d0: -16'sd1,   d1: -16'sd101,   d2: 16'sd101, last: 3'b000, exp_data: 6'b11_00_01, exp_err: 1'b1};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", err_frame, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);

    // Table-driven frames, m_ready held high
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].d0, tbl[i].last[0]);
      send(tbl[i].d1, tbl[i].last[1]);
      send(tbl[i].d2, tbl[i].last[2]);
      chk("tbl_vld", m_valid, 1);
      chk("tbl_data", m_data, tbl[i].exp_data);
      chk("tbl_err", err_frame, tbl[i].exp_err);
    end
    @(negedge clk);
    chk("idle_vld", m_valid, 0);
    chk("idle_err", err_frame, 0);

    // Backpressure: two frames held, third stalls
    m_ready = 1'b0;
    send(-16'sd200, 1'b0); send(16'sd50, 1'b0); send(16'sd300, 1'b1);
    chk("bp_a_vld", m_valid, 1);
    chk("bp_a_data", m_data, 6'b11_10_00);
    send(-16'sd100, 1'b0); send(16'sd0, 1'b0); send(16'sd100, 1'b1);
    chk("bp_full_ready", s_ready, 0);
    chk("bp_hold_data", m_data, 6'b11_10_00);
    s_valid = 1'b1; s_data = -16'sd200; s_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_stall_ready", s_ready, 0);
    chk("bp_stall_data", m_data, 6'b11_10_00);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("bp_b_vld", m_valid, 1);
    chk("bp_b_data", m_data, 6'b11_10_01);
    chk("bp_ready_back", s_ready, 1);
    m_ready = 1'b1;
    send(-16'sd200, 1'b0); send(16'sd50, 1'b0); send(16'sd300, 1'b1);
    chk("bp_c_vld", m_valid, 1);
    chk("bp_c_data", m_data, 6'b11_10_00);
    @(negedge clk);

    // Early s_last on the second beat
    send(-16'sd200, 1'b0); send(16'sd50, 1'b1);
    chk("early_err", err_frame, 1);
    chk("early_vld", m_valid, 0);
    @(negedge clk);
    chk("early_err_once", err_frame, 0);
    chk("early_vld2", m_valid, 0);
    send(-16'sd100, 1'b0); send(16'sd0, 1'b0); send(16'sd100, 1'b1);
    chk("early_next_vld", m_valid, 1);
    chk("early_next_data", m_data, 6'b11_10_01);
    chk("early_next_err", err_frame, 0);
    @(negedge clk);

    // Reset mid-frame with a vector held on the output
    m_ready = 1'b0;
    send(16'sd300, 1'b0); send(16'sd300, 1'b0); send(16'sd300, 1'b1);
    send(16'sd300, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", m_valid, 0);
    chk("mrst_data", m_data, 0);
    chk("mrst_ready", s_ready, 1);
    chk("mrst_err", err_frame, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_ready = 1'b1;
    send(-16'sd200, 1'b0); send(16'sd50, 1'b0); send(16'sd300, 1'b1);
    chk("mrst_frame_vld", m_valid, 1);
    chk("mrst_frame_data", m_data, 6'b11_10_00);
    chk("mrst_frame_err", err_frame, 0);
    @(negedge clk);
`ifdef LOGICNET_IN_STATS_EN
    chk("stats_frame_cnt", frame_cnt, 1);
    chk("stats_err_cnt", err_cnt, 0);
`endif
    chk("final_vld", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
